// File: rtl/draw_slice_column_pkg.sv
// rtl/draw_slice_column_pkg.sv - shared raycaster constants, colours and slice FSM states
// Purpose: screen geometry, palette and state encoding used by the column
//          rasteriser and its bounds helper. No ports.
package draw_slice_column_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [2:0] CEIL_COLOUR  = 3'b001;
   localparam logic [2:0] WALL_COLOUR  = 3'b100;
   localparam logic [2:0] SHADE_COLOUR = 3'b110;
   localparam logic [2:0] FLOOR_COLOUR = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_DRAW  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/draw_slice_column_bounds.sv
// rtl/draw_slice_column_bounds.sv - combinational wall top/bottom rows for one slice height
// Purpose: clamp the projected height to the screen and centre it vertically.
// Ports:
//   i_slice_size  in   7  projected wall height in rows (0..127)
//   o_top         out  8  first wall row
//   o_bot         out  8  first floor row (exclusive end of the wall)
module draw_slice_column_bounds
   import draw_slice_column_pkg::*;
(
   input  logic [6:0] i_slice_size,
   output logic [7:0] o_top,
   output logic [7:0] o_bot
);

   localparam logic [7:0] H_MAX = 8'(SCREEN_H);

   logic [7:0] w_h;
   logic [7:0] w_spare;

   always_comb begin
      w_h     = ({1'b0, i_slice_size} > H_MAX) ? H_MAX : {1'b0, i_slice_size};
      w_spare = H_MAX - w_h;
      // Floor division: an odd spare row ends up below the wall.
      o_top   = {1'b0, w_spare[7:1]};
      o_bot   = o_top + w_h;
   end

endmodule

// File: rtl/draw_slice_column.sv
// rtl/draw_slice_column.sv - rasterise one screen column as ceiling, wall and floor pixels
// Purpose: accept a column/height request, then emit SCREEN_H pixels top to
//          bottom with plot/ready backpressure and a done pulse at the end.
// Ports:
//   i_clock       in   1  system clock, rising edge
//   i_reset       in   1  asynchronous active-high reset
//   i_start       in   1  request, sampled only in IDLE
//   i_col         in   8  screen column, latched on start
//   i_slice_size  in   7  wall height in rows, latched on start
//   i_side_horiz  in   1  horizontal-grid hit selects shaded wall, latched on start
//   i_plot_ready  in   1  pixel sink accepts the current pixel
//   o_busy        out  1  column in progress
//   o_plot        out  1  pixel valid
//   o_x           out  8  pixel column
//   o_y           out  7  pixel row
//   o_colour      out  3  pixel colour
//   o_done        out  1  one-cycle pulse after the last pixel is accepted
module draw_slice_column
   import draw_slice_column_pkg::*;
(
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [7:0] i_col,
   input  logic [6:0] i_slice_size,
   input  logic       i_side_horiz,
   input  logic       i_plot_ready,
   output logic       o_busy,
   output logic       o_plot,
   output logic [7:0] o_x,
   output logic [6:0] o_y,
   output logic [2:0] o_colour,
   output logic       o_done
);

   localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_col;
   logic [6:0] r_size;
   logic       r_side;
   logic [6:0] r_y;
   logic [7:0] r_top;
   logic [7:0] r_bot;
   logic [7:0] w_top;
   logic [7:0] w_bot;
   logic [7:0] w_y_ext;

   draw_slice_column_bounds u_bounds (
      .i_slice_size (r_size),
      .o_top        (w_top),
      .o_bot        (w_bot)
   );

   assign o_x     = r_col;
   assign o_y     = r_y;
   assign w_y_ext = {1'b0, r_y};

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_col   <= '0;
         r_size  <= '0;
         r_side  <= 1'b0;
         r_y     <= '0;
         r_top   <= '0;
         r_bot   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_col  <= i_col;
                  r_size <= i_slice_size;
                  r_side <= i_side_horiz;
               end
            end
            S_SETUP: begin
               r_top <= w_top;
               r_bot <= w_bot;
               r_y   <= '0;
            end
            S_DRAW: begin
               // The last row stays put; the FSM leaves DRAW on its acceptance.
               if (i_plot_ready && (r_y != Y_LAST)) begin
                  r_y <= r_y + 7'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      w_next   = r_state;
      o_busy   = 1'b0;
      o_plot   = 1'b0;
      o_done   = 1'b0;
      o_colour = 3'b000;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next = S_SETUP;
            end
         end
         S_SETUP: begin
            o_busy = 1'b1;
            w_next = S_DRAW;
         end
         S_DRAW: begin
            o_busy = 1'b1;
            o_plot = 1'b1;
            if (w_y_ext < r_top) begin
               o_colour = CEIL_COLOUR;
            end else if (w_y_ext < r_bot) begin
               o_colour = r_side ? SHADE_COLOUR : WALL_COLOUR;
            end else begin
               o_colour = FLOOR_COLOUR;
            end
            if (i_plot_ready && (r_y == Y_LAST)) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_draw_slice_column.sv
// tb/tb_draw_slice_column.sv - self-checking bench for the column rasteriser
module tb_draw_slice_column;

   localparam logic [2:0] C_CEIL  = 3'b001;
   localparam logic [2:0] C_WALL  = 3'b100;
   localparam logic [2:0] C_SHADE = 3'b110;
   localparam logic [2:0] C_FLOOR = 3'b010;

   typedef logic [17:0] pix_t;

   logic       clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_start = 1'b0;
   logic [7:0] i_col = '0;
   logic [6:0] i_slice_size = '0;
   logic       i_side_horiz = 1'b0;
   logic       i_plot_ready = 1'b0;
   logic       o_busy;
   logic       o_plot;
   logic [7:0] o_x;
   logic [6:0] o_y;
   logic [2:0] o_colour;
   logic       o_done;

   int n_checks = 0;
   int n_fail   = 0;
   logic [2:0] obs_col [120];

   draw_slice_column dut (
      .i_clock      (clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_col        (i_col),
      .i_slice_size (i_slice_size),
      .i_side_horiz (i_side_horiz),
      .i_plot_ready (i_plot_ready),
      .o_busy       (o_busy),
      .o_plot       (o_plot),
      .o_x          (o_x),
      .o_y          (o_y),
      .o_colour     (o_colour),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] exp_colour(input int y, input int s, input logic side);
      int h;
      int top;
      h   = (s > 120) ? 120 : s;
      top = (120 - h) / 2;
      if (y < top) return C_CEIL;
      if (y < top + h) return side ? C_SHADE : C_WALL;
      return C_FLOOR;
   endfunction

   // Drives one column request and scores every presented pixel against the queue.
   task automatic run_col(input logic [7:0] c, input logic [6:0] s, input logic side,
                          input int stall_y, input int stall_n, input int poke_y,
                          input int rst_y, output int done_k, output int npix);
      pix_t q[$];
      int   stalls;
      bit   poked;
      bit   was_reset;
      pix_t got;
      stalls    = stall_n;
      poked     = 0;
      was_reset = 0;
      done_k    = -1;
      npix      = 0;
      for (int i = 0; i < 120; i++) begin
         obs_col[i] = 3'b000;
         q.push_back({c, 7'(i), exp_colour(i, int'(s), side)});
      end
      @(negedge clk);
      i_col        = c;
      i_slice_size = s;
      i_side_horiz = side;
      i_start      = 1'b1;
      i_plot_ready = 1'b1;
      @(posedge clk);
      #1;
      i_start      = 1'b0;
      i_col        = ~c;
      i_slice_size = ~s;
      i_side_horiz = ~side;
      for (int k = 1; k < 400; k++) begin
         @(negedge clk);
         if (k == 1) begin
            n_checks++;
            if (o_busy !== 1'b1 || o_plot !== 1'b0)
               $display("FAIL busy_after_start: busy=%b plot=%b required busy=1 plot=0", o_busy, o_plot);
         end
         if (poked) begin
            i_start = 1'b0;
            i_col   = ~c;
         end
         i_plot_ready = 1'b1;
         if (o_plot && int'(o_y) == stall_y && stalls > 0) begin
            i_plot_ready = 1'b0;
            stalls--;
         end
         if (o_plot && int'(o_y) == poke_y && !poked) begin
            i_start = 1'b1;
            i_col   = 8'd9;
            poked   = 1;
         end
         if (o_plot) begin
            got = {o_x, o_y, o_colour};
            n_checks++;
            if (q.size() == 0) begin
               $display("FAIL extra_pixel: x=%0d y=%0d colour=%b required none", o_x, o_y, o_colour);
               n_fail++;
            end else begin
               if (got !== q[0]) begin
                  $display("FAIL pixel: x=%0d y=%0d colour=%b required x=%0d y=%0d colour=%b",
                           o_x, o_y, o_colour, q[0][17:10], q[0][9:3], q[0][2:0]);
                  n_fail++;
               end
               if (i_plot_ready) begin
                  if (o_y < 7'd120) obs_col[o_y] = o_colour;
                  void'(q.pop_front());
                  npix++;
               end
            end
            if (int'(o_y) == rst_y) begin
               i_reset = 1'b1;
               #1;
               n_checks++;
               if (o_plot !== 1'b0 || o_busy !== 1'b0) begin
                  $display("FAIL reset_mid_draw: plot=%b busy=%b required 0 0", o_plot, o_busy);
                  n_fail++;
               end
               @(negedge clk);
               i_reset   = 1'b0;
               was_reset = 1;
               break;
            end
         end
         if (o_done) begin
            done_k = k;
            break;
         end
      end
      i_start = 1'b0;
      if (!was_reset) begin
         n_checks++;
         if (q.size() != 0) begin
            $display("FAIL missing_pixels: %0d left, required 0", q.size());
            n_fail++;
         end
      end
   endtask

   task automatic test_reset;
      i_reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({o_busy, o_plot, o_x, o_y, o_colour, o_done} !== '0) begin
         $display("FAIL reset_state: busy=%b plot=%b x=%0d y=%0d colour=%b done=%b required all 0",
                  o_busy, o_plot, o_x, o_y, o_colour, o_done);
         n_fail++;
      end
      i_reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (o_busy !== 1'b0 || o_plot !== 1'b0) begin
         $display("FAIL idle_after_reset: busy=%b plot=%b required 0 0", o_busy, o_plot);
         n_fail++;
      end
   endtask

   task automatic test_basic;
      int k, n;
      run_col(8'd5, 7'd40, 1'b0, -1, 0, -1, -1, k, n);
      n_checks++;
      if (k != 122 || n != 120) begin
         $display("FAIL basic_timing: done_cycle=%0d pixels=%0d required 122 120", k, n);
         n_fail++;
      end
      n_checks++;
      if (obs_col[39] !== C_CEIL || obs_col[40] !== C_WALL || obs_col[79] !== C_WALL || obs_col[80] !== C_FLOOR) begin
         $display("FAIL basic_edges: y39=%b y40=%b y79=%b y80=%b required 001 100 100 010",
                  obs_col[39], obs_col[40], obs_col[79], obs_col[80]);
         n_fail++;
      end
   endtask

   task automatic test_shade;
      int k, n;
      run_col(8'd17, 7'd41, 1'b1, -1, 0, -1, -1, k, n);
      n_checks++;
      if (obs_col[38] !== C_CEIL || obs_col[39] !== C_SHADE || obs_col[79] !== C_SHADE || obs_col[80] !== C_FLOOR) begin
         $display("FAIL shade_edges: y38=%b y39=%b y79=%b y80=%b required 001 110 110 010",
                  obs_col[38], obs_col[39], obs_col[79], obs_col[80]);
         n_fail++;
      end
   endtask

   task automatic test_bounds;
      int k, n;
      run_col(8'd0, 7'd0, 1'b0, -1, 0, -1, -1, k, n);
      n_checks++;
      if (obs_col[59] !== C_CEIL || obs_col[60] !== C_FLOOR || n != 120) begin
         $display("FAIL zero_height: y59=%b y60=%b pixels=%0d required 001 010 120", obs_col[59], obs_col[60], n);
         n_fail++;
      end
      run_col(8'd159, 7'd127, 1'b0, -1, 0, -1, -1, k, n);
      n_checks++;
      if (obs_col[0] !== C_WALL || obs_col[119] !== C_WALL || n != 120 || k != 122) begin
         $display("FAIL full_height: y0=%b y119=%b pixels=%0d done_cycle=%0d required 100 100 120 122",
                  obs_col[0], obs_col[119], n, k);
         n_fail++;
      end
   endtask

   task automatic test_stall;
      int k, n;
      run_col(8'd5, 7'd40, 1'b0, 50, 3, -1, -1, k, n);
      n_checks++;
      if (k != 125 || n != 120) begin
         $display("FAIL stall_timing: done_cycle=%0d pixels=%0d required 125 120", k, n);
         n_fail++;
      end
   endtask

   task automatic test_ignore_start;
      int k, n;
      int extra;
      run_col(8'd5, 7'd40, 1'b0, -1, 0, 10, -1, k, n);
      n_checks++;
      if (k != 122 || n != 120) begin
         $display("FAIL busy_start: done_cycle=%0d pixels=%0d required 122 120", k, n);
         n_fail++;
      end
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (o_done || o_busy) extra++;
      end
      n_checks++;
      if (extra != 0) begin
         $display("FAIL no_extra_done: %0d active cycles required 0", extra);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid;
      int k, n;
      run_col(8'd5, 7'd40, 1'b0, -1, 0, -1, 70, k, n);
      n_checks++;
      if (k != -1 || o_done !== 1'b0) begin
         $display("FAIL abandoned_done: done_cycle=%0d done=%b required none", k, o_done);
         n_fail++;
      end
      run_col(8'd33, 7'd90, 1'b1, -1, 0, -1, -1, k, n);
      n_checks++;
      if (k != 122 || n != 120) begin
         $display("FAIL after_reset: done_cycle=%0d pixels=%0d required 122 120", k, n);
         n_fail++;
      end
   endtask

   task automatic test_back_to_back;
      int k, n;
      run_col(8'd77, 7'd100, 1'b0, -1, 0, -1, -1, k, n);
      i_start = 1'b1;
      i_col   = 8'd1;
      @(negedge clk);
      i_start = 1'b0;
      n_checks++;
      if (o_busy !== 1'b0) begin
         $display("FAIL start_on_done: busy=%b required 0", o_busy);
         n_fail++;
      end
      @(negedge clk);
      n_checks++;
      if (o_busy !== 1'b0 || o_plot !== 1'b0) begin
         $display("FAIL start_on_done_late: busy=%b plot=%b required 0 0", o_busy, o_plot);
         n_fail++;
      end
      run_col(8'd100, 7'd60, 1'b1, -1, 0, -1, -1, k, n);
      n_checks++;
      if (k != 122 || n != 120) begin
         $display("FAIL back_to_back: done_cycle=%0d pixels=%0d required 122 120", k, n);
         n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_shade();
      test_bounds();
      test_stall();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
